// File: rtl/alu_op_sequencer.sv
// Issue stage for the 8-bit compare/logic ALU: queues commands, parks ctrl
// at zero before each issue, captures the ALU result and hands it back.
module alu_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_ctrl,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    output logic [3:0]               alu_ctrl,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    input  logic [7:0]               alu_s,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_data,
    output logic [3:0]               res_ctrl,
    output logic                     res_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        PARK,
        DRIVE,
        HOLD
    } state_t;

    state_t state;
    state_t state_n;

    logic [3:0]    q_ctrl [DEPTH];
    logic [7:0]    q_a    [DEPTH];
    logic [7:0]    q_b    [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic       push;
    logic       pop;
    logic       empty;
    logic       full;
    logic [3:0] cur_ctrl;
    logic       cur_legal;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign cmd_ready  = !full;
    assign push       = cmd_valid && cmd_ready;
    assign fifo_count = count;
    assign busy       = (state != IDLE) || !empty;
    assign cur_legal  = (cur_ctrl >= 4'd2) && (cur_ctrl <= 4'd11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_ctrl[i] <= '0;
                q_a[i]    <= '0;
                q_b[i]    <= '0;
            end
        end else if (push) begin
            q_ctrl[wr_ptr] <= cmd_ctrl;
            q_a[wr_ptr]    <= cmd_a;
            q_b[wr_ptr]    <= cmd_b;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = PARK;
                end
            end
            PARK: begin
                state_n = DRIVE;
            end
            DRIVE: begin
                state_n = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = PARK;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ctrl is only non-zero during DRIVE, so every issue is a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            cur_ctrl  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_ctrl  <= '0;
            res_err   <= 1'b0;
        end else begin
            if (pop) begin
                alu_a    <= q_a[rd_ptr];
                alu_b    <= q_b[rd_ptr];
                cur_ctrl <= q_ctrl[rd_ptr];
            end
            if ((state_n == DRIVE) && cur_legal) begin
                alu_ctrl <= cur_ctrl;
            end else begin
                alu_ctrl <= 4'd0;
            end
            if (state == DRIVE) begin
                res_valid <= 1'b1;
                res_data  <= cur_legal ? alu_s : 8'h00;
                res_ctrl  <= cur_ctrl;
                res_err   <= !cur_legal;
            end else if ((state == HOLD) && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream issue stage for the 8-bit compare/logic ALU block.
- Accepts operation commands (ctrl, a, b) over a valid/ready handshake and queues them in a small FIFO.
- Drives one command at a time onto the ALU's combinational inputs, captures the ALU result and returns it over a second valid/ready handshake.
- The ALU evaluates only when its ctrl input changes, so this block parks ctrl at 0 for one cycle before every issue. Back-to-back identical ops therefore always re-evaluate.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_ctrl  in  4  ALU op code
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- alu_ctrl  out  4  to ALU ctrl
- alu_a  out  8  to ALU a
- alu_b  out  8  to ALU b
- alu_s  in  8  ALU result s
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  8  captured result
- res_ctrl  out  4  op code echoed with result
- res_err  out  1  op code was illegal
- busy  out  1  FIFO non-empty or state != IDLE
- fifo_count  out  $clog2(DEPTH)+1  queued entries

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; FIFO emptied; fifo_count=0.
  - alu_ctrl=0, alu_a=0, alu_b=0.
  - res_valid=0, res_data=0, res_ctrl=0, res_err=0; busy=0.
  - Queued and in-flight ops are dropped, with no partial result.
  - All outputs are registered except cmd_ready and busy, which are decoded from registers.
- Legal op codes: 2..11 (2 transfer, 3 inc, 4 dec, 5 ones-adjust, 6 NOR, 7 XOR, 8 XNOR, 9 GT, 10 LT, 11 EQ). Codes 0, 1 and 12..15 are illegal.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - Pop when the FSM leaves IDLE or HOLD toward PARK.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - When full, cmd_ready=0 and there is no bypass.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, PARK, DRIVE, HOLD.
  - IDLE: if FIFO non-empty, pop the head and go to PARK; otherwise stay. alu_ctrl=0.
  - PARK (1 cycle): alu_a/alu_b = popped operands; alu_ctrl=0. Go to DRIVE.
  - DRIVE (1 cycle): alu_ctrl = op if legal, else 0.
    - At the end of the cycle, capture res_data = legal ? alu_s : 8'h00, res_ctrl=op, res_err=!legal.
    - Set res_valid=1 and go to HOLD.
  - HOLD: res_valid=1; res_data, res_ctrl and res_err are stable.
    - alu_ctrl returns to 0; alu_a/alu_b hold.
    - On res_valid && res_ready: clear res_valid. Go to PARK with a pop if the FIFO is non-empty, else go to IDLE.
- Latency: command accepted at cycle N with FIFO empty and FSM idle → PARK at N+2, DRIVE at N+3, res_valid high at N+4.
- Throughput: with res_ready held high, one result every 3 cycles (PARK, DRIVE, HOLD).
- Illegal op: takes the same timing as a legal op; alu_ctrl never shows the illegal code.
- Commands arriving while the FSM is busy queue normally. They are accepted in HOLD even when res_ready=0.
- Width rule: no arithmetic in this block. alu_s is captured verbatim (ALU wraps inc 0xFF→0x00).

Test Plan:
- Single XOR: ctrl=7, a=0x5A, b=0x0F accepted at cycle N → res_valid at N+4, res_data=0x55, res_ctrl=7, res_err=0.
- Compare and wrap: ctrl=9, a=0x80, b=0x7F → res_data=0x01; then ctrl=3, a=0xFF → res_data=0x00.
- Repeated op: two back-to-back ctrl=3 ops with a=0x10 then a=0x20, res_ready=1 → alu_ctrl sequence 0,3,0,0,3; results 0x11 then 0x21, 3 cycles apart.
- Illegal code: ctrl=14, a=0xAA → res_data=0x00, res_err=1, res_ctrl=14; alu_ctrl stays 0 throughout.
- Backpressure (DEPTH=4): res_ready=0, offer 6 commands continuously → 5 accepted (1 in HOLD, 4 queued), cmd_ready=0 with fifo_count=4. Then raise res_ready → results drain in order, and cmd_ready rises the cycle after the first pop.
- Reset mid-op: assert rst_n=0 while in DRIVE with 2 queued → outputs immediately at reset values. After release, busy=0 and no res_valid appears without new commands.
